sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Single-clock, parametrised FIFO with configurable width, depth, almost-full/almost-empty thresholds and read-output mode. It adds an occupancy count, sticky overflow/underflow error flags and a synchronous flush. It is the next-generation DUT for the FIFO verification environment. Write-side and read-side signal names match the existing write/read bundles, so the existing drivers and receivers attach with only a clock/reset change.

## Interface
- DSIZE, 8: data width in bits.
- ASIZE, 4: address width; depth = 2**ASIZE (16).
- AFULL, 2**ASIZE-2 (14): count at or above which walmost_full asserts.
- AEMPTY, 2: count at or below which ralmost_empty asserts.
- RDREG, 0: 0 = show-ahead (rdata combinational from head entry); 1 = registered rdata.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush.
- winc  in  1  write request.
- wdata  in  DSIZE  write data.
- wfull  out  1  FIFO full.
- walmost_full  out  1  count >= AFULL.
- rinc  in  1  read request.
- rdata  out  DSIZE  read data.
- rempty  out  1  FIFO empty.
- ralmost_empty  out  1  count <= AEMPTY.
- count  out  ASIZE+1  current occupancy, 0..2**ASIZE.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

## Operation
- **Pointers.**
  - wptr and rptr are ASIZE+1 bits; the low ASIZE bits address the memory.
  - The MSB is the wrap bit.
- **Flags.**
  - rempty = (wptr == rptr).
  - wfull = low bits equal and MSBs differ.
  - count = wptr - rptr, modulo 2**(ASIZE+1).
  - All flags and count decode from the registered pointers only. They never decode from the current-cycle winc/rinc.
- **Write accept** = winc && !wfull. It writes mem[wptr] and increments wptr.
- **Read accept** = rinc && !rempty. It increments rptr.
- **Simultaneous winc/rinc.**
  - Both are accepted when neither flag blocks them; count is unchanged.
  - When full: the read is accepted and the write is rejected, setting overflow.
  - When empty: the write is accepted and the read is rejected, setting underflow. There is no bypass.
- **Error flags.**
  - winc && wfull sets overflow.
  - rinc && rempty sets underflow.
  - Both stay set until rst or clr.
- **RDREG=0.** rdata = mem[rptr]. It is valid whenever rempty=0. A read accept advances rdata to the next entry.
- **RDREG=1.**
  - On a read accept, rdata <= mem[rptr] at that edge, so data is visible the cycle after rinc.
  - rdata holds its value otherwise.
- **clr.**
  - Sets wptr = rptr = 0, clears overflow and underflow, and zeroes registered rdata.
  - Has priority over winc/rinc in the same cycle.
  - Memory contents are not cleared.
- **Pointer wrap.** Pointers wrap naturally modulo 2**(ASIZE+1). There is no special case at the wrap point.

## Timing
- **Reset values** (asynchronous on rst rising, no clock needed):
  - wptr = rptr = 0, count = 0.
  - wfull = 0, rempty = 1.
  - walmost_full = 0, ralmost_empty = 1.
  - overflow = underflow = 0.
  - rdata = 0 when RDREG=1.
  - Memory is not reset.
- Reset mid-operation discards all contents. The first write after rst deasserts is accepted on the next rising edge.
- **Write-to-read latency:**
  - Data written at edge N makes rempty fall after edge N.
  - RDREG=0: rdata is valid in cycle N+1.
  - RDREG=1: rinc in cycle N+1 produces rdata in cycle N+2.
- Full/empty/almost flags and count update in the cycle after the accepting edge; there is no combinational path from winc/rinc.
- The only combinational input-to-output path is rptr -> rdata in RDREG=0 mode.

## Structure
- **Shared package fifo_pkg:**
  - default DSIZE/ASIZE constants;
  - a ptr_t width helper function (ASIZE+1);
  - functions is_full(wptr, rptr) and is_empty(wptr, rptr), reusable by the behavioural model.
- **Sub-module fifo_mem:**
  - 2**ASIZE x DSIZE register array;
  - one synchronous write port (we, waddr, wdata);
  - one asynchronous read port (raddr -> rdata).
- The top level holds the pointers, flags, error registers and the RDREG output stage, selected by a generate block.

## Test plan
- **Reset and basic flow.** rst pulse, then write 0x11,0x22,0x33, then read 3 -> rdata 0x11,0x22,0x33 in order; count 0->3->0; rempty 1->0->1.
- **Fill to full.** 16 writes of 0x00..0x0F -> wfull=1, count=16, walmost_full rises after the 14th write. A 17th winc with 0xAA sets overflow; reading all 16 returns 0x00..0x0F and no 0xAA.
- **Empty read.** rinc on an empty FIFO -> underflow=1 and rptr unchanged. A subsequent write of 0x5A then rinc -> rdata 0x5A.
- **Simultaneous operation.**
  - At full: winc+rinc -> read accepted, write rejected, count 16->15, overflow set.
  - At empty: winc+rinc -> count 0->1, underflow set.
  - At count 5: both accepted, count stays 5.
- **Wrap-around.** 40 writes interleaved with reads, keeping count between 1 and 10 -> data order preserved across two pointer wraps; rempty/wfull never falsely assert.
- **clr and mid-operation reset.**
  - With count=7 and overflow set: clr with winc the same cycle -> count 0, rempty 1, overflow 0, write dropped.
  - With count=9: rst asserted mid-burst -> all outputs return to reset values asynchronously.
  - With RDREG=1: rdata=0 after clr or rst.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO defaults, pointer width helper and full/empty decode
package fifo_pkg;
  localparam int DSIZE_DEF = 8;
  localparam int ASIZE_DEF = 4;
  function automatic int ptr_w(input int asize);
    return asize + 1;
  endfunction
  function automatic logic is_full(input logic [31:0] wptr, input logic [31:0] rptr, input int asize);
    logic [31:0] m;
    m = (32'd1 << (asize + 1)) - 32'd1;
    return ((wptr ^ rptr) & m) == (32'd1 << asize);
  endfunction
  function automatic logic is_empty(input logic [31:0] wptr, input logic [31:0] rptr, input int asize);
    logic [31:0] m;
    m = (32'd1 << (asize + 1)) - 32'd1;
    return ((wptr ^ rptr) & m) == 32'd0;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: 2**ASIZE x DSIZE register array; sync write (we/waddr/wdata), async read (raddr->rdata)
module fifo_mem #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
)(
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);
  logic [DSIZE-1:0] mem [2**ASIZE];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO (clk/rst/clr; winc/wdata/wfull/walmost_full; rinc/rdata/rempty/ralmost_empty; count; sticky overflow/underflow)
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DSIZE  = DSIZE_DEF,
  parameter int ASIZE  = ASIZE_DEF,
  parameter int AFULL  = 2**ASIZE - 2,
  parameter int AEMPTY = 2,
  parameter int RDREG  = 0
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);
  localparam int PW = ptr_w(ASIZE);
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic ovf_q, ovf_d, unf_q, unf_d, w_acc, r_acc;
  logic [DSIZE-1:0] mem_rdata;
  always_comb begin
    wfull         = is_full(32'(wptr_q), 32'(rptr_q), ASIZE);
    rempty        = is_empty(32'(wptr_q), 32'(rptr_q), ASIZE);
    count         = wptr_q - rptr_q;
    walmost_full  = int'(count) >= AFULL;
    ralmost_empty = int'(count) <= AEMPTY;
    w_acc         = winc && !wfull;
    r_acc         = rinc && !rempty;
    wptr_d        = clr ? '0 : wptr_q + PW'(w_acc);
    rptr_d        = clr ? '0 : rptr_q + PW'(r_acc);
    ovf_d         = !clr && (ovf_q || (winc && wfull));
    unf_d         = !clr && (unf_q || (rinc && rempty));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  fifo_mem #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_mem (
    .clk   (clk),
    .we    (w_acc && !clr),
    .waddr (wptr_q[ASIZE-1:0]),
    .wdata (wdata),
    .raddr (rptr_q[ASIZE-1:0]),
    .rdata (mem_rdata)
  );
  if (RDREG != 0) begin : g_reg
    logic [DSIZE-1:0] rdata_q, rdata_d;
    always_comb rdata_d = clr ? '0 : r_acc ? mem_rdata : rdata_q;
    always_ff @(posedge clk or posedge rst)
      if (rst) rdata_q <= '0;
      else rdata_q <= rdata_d;
    assign rdata = rdata_q;
  end else begin : g_sa
    assign rdata = mem_rdata;
  end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: random and directed stimulus against a queue model, show-ahead and registered instances
module tb_sync_fifo_param;
  logic clk = 1'b0, rst, clr, winc, rinc;
  logic [7:0] wdata, rdata0, rdata1;
  logic wfull0, wafull0, rempty0, raempty0, ovf0, unf0;
  logic wfull1, wafull1, rempty1, raempty1, ovf1, unf1;
  logic [4:0] count0, count1;
  int n_chk = 0, n_err = 0;
  logic [7:0] q[$];
  logic m_ovf, m_unf;
  logic [7:0] m_rreg;
  always #5 clk = ~clk;
  sync_fifo_param #(.RDREG(0)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .winc(winc), .wdata(wdata), .wfull(wfull0),
    .walmost_full(wafull0), .rinc(rinc), .rdata(rdata0), .rempty(rempty0),
    .ralmost_empty(raempty0), .count(count0), .overflow(ovf0), .underflow(unf0));
  sync_fifo_param #(.RDREG(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .winc(winc), .wdata(wdata), .wfull(wfull1),
    .walmost_full(wafull1), .rinc(rinc), .rdata(rdata1), .rempty(rempty1),
    .ralmost_empty(raempty1), .count(count1), .overflow(ovf1), .underflow(unf1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_clear();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rreg = 8'h00;
  endtask
  task automatic check_all();
    int n = q.size();
    chk("count0", 32'(count0), 32'(n));
    chk("count1", 32'(count1), 32'(n));
    chk("rempty", 32'(rempty0), 32'(n == 0));
    chk("wfull", 32'(wfull0), 32'(n == 16));
    chk("walmost_full", 32'(wafull0), 32'(n >= 14));
    chk("ralmost_empty", 32'(raempty0), 32'(n <= 2));
    chk("overflow", 32'(ovf0), 32'(m_ovf));
    chk("underflow", 32'(unf0), 32'(m_unf));
    chk("flags_reg", 32'({wfull1, wafull1, rempty1, raempty1, ovf1, unf1}),
        32'({wfull0, wafull0, rempty0, raempty0, ovf0, unf0}));
    chk("rdata_reg", 32'(rdata1), 32'(m_rreg));
    if (n > 0) chk("rdata_sa", 32'(rdata0), 32'(q[0]));
  endtask
  task automatic tick(input logic w, input logic [7:0] d, input logic r, input logic c);
    bit full, empty;
    winc = w; wdata = d; rinc = r; clr = c;
    @(posedge clk);
    if (c) model_clear();
    else begin
      full = q.size() == 16;
      empty = q.size() == 0;
      if (w && full) m_ovf = 1'b1;
      if (r && empty) m_unf = 1'b1;
      if (r && !empty) m_rreg = q.pop_front();
      if (w && !full) q.push_back(d);
    end
    #1 check_all();
  endtask
  task automatic do_rst();
    winc = 0; rinc = 0; clr = 0;
    #2 rst = 1'b1;
    model_clear();
    #1 check_all();
    @(negedge clk) rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1; clr = 0; winc = 0; rinc = 0; wdata = 0;
    model_clear();
    #2 check_all();
    @(negedge clk) rst = 1'b0;
    foreach (q[i]) ;
    tick(1, 8'h11, 0, 0); tick(1, 8'h22, 0, 0); tick(1, 8'h33, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 0);
    for (int i = 0; i < 16; i++) tick(1, 8'(i), 0, 0);
    tick(1, 8'hAA, 0, 0);
    for (int i = 0; i < 16; i++) tick(0, 0, 1, 0);
    tick(0, 0, 1, 0);
    tick(1, 8'h5A, 0, 0);
    tick(0, 0, 1, 0);
    do_rst();
    for (int i = 0; i < 16; i++) tick(1, 8'($urandom), 0, 0);
    tick(1, 8'hEE, 1, 0);
    for (int i = 0; i < 15; i++) tick(0, 0, 1, 0);
    tick(1, 8'h77, 1, 0);
    for (int i = 0; i < 4; i++) tick(1, 8'($urandom), 0, 0);
    tick(1, 8'h99, 1, 0);
    do_rst();
    begin
      int writes = 0, cyc = 0;
      tick(1, 8'($urandom), 0, 0);
      writes = 1;
      while (writes < 40 && cyc < 2000) begin
        logic w, r;
        w = (q.size() < 10) && ($urandom_range(0, 2) != 0);
        r = (q.size() > 1) && ($urandom_range(0, 2) != 0);
        if (w) writes++;
        tick(w, 8'($urandom), r, 0);
        cyc++;
      end
      chk("wrap_writes", 32'(writes), 32'd40);
    end
    do_rst();
    for (int i = 0; i < 16; i++) tick(1, 8'($urandom), 0, 0);
    tick(1, 8'hAB, 0, 0);
    for (int i = 0; i < 9; i++) tick(0, 0, 1, 0);
    tick(1, 8'hCD, 0, 1);
    tick(0, 0, 1, 0);
    for (int i = 0; i < 9; i++) tick(1, 8'($urandom), 0, 0);
    do_rst();
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1,
           $urandom_range(0, 39) == 0);
    for (int i = 0; i < 20; i++) tick(1, 8'($urandom), 0, 0);
    tick(0, 0, 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
